// File: rtl/ddr3_read_capture_ctrl.sv
// ddr3_read_capture_ctrl: read sequencer for an 8-deep DDR3 read-capture ring buffer.
// Accepts read-issue events, pulses `listen` at the programmed delay, drains the eight
// captured words through `readPtr` and returns them tagged and framed with valid/last.
// Issues arriving closer than MIN_GAP cycles apart are dropped and flagged.
// Optional feature: define DDR3_RDCTRL_CWF_EN for critical-word-first drain order,
// which adds the `rd_col` input.

module ddr3_read_capture_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned LISTEN_DLY = 6,
    parameter int unsigned DRAIN_DLY  = 5,
    parameter int unsigned MIN_GAP    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_issue,
    input  logic [TAG_W-1:0]  rd_tag_in,
`ifdef DDR3_RDCTRL_CWF_EN
    input  logic [2:0]        rd_col,
`endif
    input  logic [DATA_W-1:0] buf_dout,
    input  logic              err_clr,
    output logic              listen,
    output logic [2:0]        readPtr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_last,
    output logic              busy,
    output logic              overrun_err
);

    localparam int unsigned DEPTH = LISTEN_DLY + DRAIN_DLY;
    localparam int unsigned GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP - 1);

    typedef enum logic {StIdle, StDrain} state_t;

    logic [GAP_W-1:0] gap_q;
    logic             gap_ready;
    logic             accept;
    logic             drop;

    // Shift pipeline: stage i is valid during cycle T+1+i for an issue accepted in cycle T.
    logic [DEPTH-1:0] pipe_vld_q;
    logic [TAG_W-1:0] pipe_tag_q [DEPTH-1];
`ifdef DDR3_RDCTRL_CWF_EN
    logic [2:0]       pipe_col_q [DEPTH-1];
`endif

    // Tap is taken one stage early so the first drain cycle lands in T+LISTEN_DLY+DRAIN_DLY
    // with readPtr already registered.
    logic             tap;
    logic [TAG_W-1:0] tap_tag;
    logic [2:0]       tap_col;

    state_t           state_q;
    logic [2:0]       k_q;
    logic [TAG_W-1:0] burst_tag_q;

    assign gap_ready = (gap_q == GAP_MAX);
    assign accept    = rd_issue & gap_ready;
    assign drop      = rd_issue & ~gap_ready;

    assign tap     = pipe_vld_q[DEPTH-2];
    assign tap_tag = pipe_tag_q[DEPTH-2];
`ifdef DDR3_RDCTRL_CWF_EN
    assign tap_col = pipe_col_q[DEPTH-2];
`else
    assign tap_col = 3'd0;
`endif

    assign listen = pipe_vld_q[LISTEN_DLY-1];
    assign busy   = (|pipe_vld_q) | (state_q == StDrain) | rd_valid;

    // Issue spacing counter; saturates at MIN_GAP-1 meaning "ready for a new issue".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q <= GAP_MAX;
        end else if (accept) begin
            gap_q <= '0;
        end else if (!gap_ready) begin
            gap_q <= gap_q + 1'b1;
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_err <= 1'b0;
        end else if (drop) begin
            overrun_err <= 1'b1;
        end else if (err_clr) begin
            overrun_err <= 1'b0;
        end
    end

    // Launch pipeline carrying valid and burst attributes from issue to drain start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < DEPTH - 1; i++) begin
                pipe_tag_q[i] <= '0;
`ifdef DDR3_RDCTRL_CWF_EN
                pipe_col_q[i] <= '0;
`endif
            end
        end else begin
            pipe_vld_q    <= {pipe_vld_q[DEPTH-2:0], accept};
            pipe_tag_q[0] <= rd_tag_in;
`ifdef DDR3_RDCTRL_CWF_EN
            pipe_col_q[0] <= rd_col;
`endif
            for (int i = 1; i < DEPTH - 1; i++) begin
                pipe_tag_q[i] <= pipe_tag_q[i-1];
`ifdef DDR3_RDCTRL_CWF_EN
                pipe_col_q[i] <= pipe_col_q[i-1];
`endif
            end
        end
    end

    // Drain FSM with registered read pointer and return-path outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= 3'd0;
            burst_tag_q <= '0;
            readPtr     <= 3'd0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_tag      <= '0;
            rd_last     <= 1'b0;
        end else begin
            rd_valid <= (state_q == StDrain);
            rd_last  <= (state_q == StDrain) && (k_q == 3'd7);
            rd_data  <= (state_q == StDrain) ? buf_dout : '0;
            rd_tag   <= (state_q == StDrain) ? burst_tag_q : '0;
            unique case (state_q)
                StIdle: begin
                    if (tap) begin
                        state_q     <= StDrain;
                        k_q         <= 3'd0;
                        burst_tag_q <= tap_tag;
                        readPtr     <= tap_col;
                    end
                end
                StDrain: begin
                    if (k_q != 3'd7) begin
                        k_q     <= k_q + 3'd1;
                        readPtr <= readPtr + 3'd1;
                    end else if (tap) begin
                        // Seamless back-to-back burst.
                        k_q         <= 3'd0;
                        burst_tag_q <= tap_tag;
                        readPtr     <= tap_col;
                    end else begin
                        state_q <= StIdle;
                        k_q     <= 3'd0;
                        readPtr <= 3'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A new burst may only start on the last word of the current one.
    a_no_early_tap: assert property (@(posedge clk) disable iff (reset)
        !(tap && (state_q == StDrain) && (k_q != 3'd7)));

endmodule

// File: tb/tb_ddr3_read_capture_ctrl.sv
// tb_ddr3_read_capture_ctrl: scoreboard bench for ddr3_read_capture_ctrl.
// Expected words and listen cycles are queued when an issue is driven and compared
// when the DUT produces them. Honours DDR3_RDCTRL_CWF_EN when defined.

module tb_ddr3_read_capture_ctrl;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned LISTEN_DLY = 6;
    localparam int unsigned DRAIN_DLY  = 5;
    localparam int unsigned MIN_GAP    = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              last;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_issue;
    logic [TAG_W-1:0]  rd_tag_in;
`ifdef DDR3_RDCTRL_CWF_EN
    logic [2:0]        rd_col;
`endif
    logic [DATA_W-1:0] buf_dout;
    logic              err_clr;
    logic              listen;
    logic [2:0]        readPtr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_last;
    logic              busy;
    logic              overrun_err;

    logic [DATA_W-1:0] mem [8];
    exp_t              sb [$];
    int                lq [$];
    int                cyc = 0;
    int                last_acc = -1000;
    int                n_tests = 0;
    int                n_fail = 0;

    ddr3_read_capture_ctrl #(
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W),
        .LISTEN_DLY (LISTEN_DLY),
        .DRAIN_DLY  (DRAIN_DLY),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_issue    (rd_issue),
        .rd_tag_in   (rd_tag_in),
`ifdef DDR3_RDCTRL_CWF_EN
        .rd_col      (rd_col),
`endif
        .buf_dout    (buf_dout),
        .err_clr     (err_clr),
        .listen      (listen),
        .readPtr     (readPtr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_last     (rd_last),
        .busy        (busy),
        .overrun_err (overrun_err)
    );

    // Ring buffer model: combinational read from readPtr.
    assign buf_dout = mem[readPtr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 8; i++) mem[i] = DATA_W'($urandom);
    endtask

    // Drive one issue in the current cycle; queue expectations if the gap model accepts it.
    task automatic issue(input logic [TAG_W-1:0] tag, input logic [2:0] col);
        logic [2:0] eff;
        logic [2:0] idx;
`ifdef DDR3_RDCTRL_CWF_EN
        eff    = col;
        rd_col = col;
`else
        eff = 3'd0;
`endif
        rd_issue  = 1'b1;
        rd_tag_in = tag;
        if (cyc - last_acc >= int'(MIN_GAP)) begin
            last_acc = cyc;
            lq.push_back(cyc + int'(LISTEN_DLY));
            for (int i = 0; i < 8; i++) begin
                idx = eff + 3'(i);
                sb.push_back('{data: mem[idx], tag: tag, last: (i == 7),
                               cyc: cyc + int'(LISTEN_DLY + DRAIN_DLY) + 1 + i});
            end
        end
        step(1);
        rd_issue = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || lq.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        check_eq("drain_done", 32'(sb.size() + lq.size()), 32'd0);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   lc;
        if (rd_valid) begin
            check_eq("unexp_valid", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("rd_data", 32'(rd_data), 32'(e.data));
                check_eq("rd_tag", 32'(rd_tag), 32'(e.tag));
                check_eq("rd_last", 32'(rd_last), 32'(e.last));
                check_eq("word_cyc", cyc, e.cyc);
            end
        end
        if (listen) begin
            check_eq("unexp_listen", 32'(lq.size() == 0), 32'd0);
            if (lq.size() != 0) begin
                lc = lq.pop_front();
                check_eq("listen_cyc", cyc, lc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, failed count %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rd_issue  = 1'b0;
        rd_tag_in = '0;
        err_clr   = 1'b0;
`ifdef DDR3_RDCTRL_CWF_EN
        rd_col    = 3'd0;
`endif
        load_mem();
        step(3);
        check_eq("rst_listen", 32'(listen), 32'd0);
        check_eq("rst_readptr", 32'(readPtr), 32'd0);
        check_eq("rst_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_data", 32'(rd_data), 32'd0);
        check_eq("rst_tag", 32'(rd_tag), 32'd0);
        check_eq("rst_last", 32'(rd_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(overrun_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(3);

        // Single read.
        load_mem();
        issue(4'h5, 3'd0);
        check_eq("busy_after_issue", 32'(busy), 32'd1);
        wait_drain();
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("readptr_idle", 32'(readPtr), 32'd0);

        // Back-to-back at exactly MIN_GAP.
        step(2);
        load_mem();
        issue(4'h1, 3'd0);
        step(MIN_GAP - 1);
        issue(4'h2, 3'd0);
        wait_drain();
        check_eq("b2b_busy_idle", 32'(busy), 32'd0);

        // Overrun: second issue five cycles later is dropped.
        step(2);
        load_mem();
        issue(4'h3, 3'd0);
        step(4);
        issue(4'h4, 3'd0);
        check_eq("ovr_set", 32'(overrun_err), 32'd1);
        wait_drain();
        check_eq("ovr_sticky", 32'(overrun_err), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check_eq("ovr_cleared", 32'(overrun_err), 32'd0);

        // Set/clear collision: drop in the same cycle as err_clr keeps the flag.
        step(2);
        issue(4'h6, 3'd0);
        step(2);
        err_clr = 1'b1;
        issue(4'h7, 3'd0);
        err_clr = 1'b0;
        check_eq("collide_err", 32'(overrun_err), 32'd1);
        wait_drain();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check_eq("collide_cleared", 32'(overrun_err), 32'd0);

        // Reset mid-drain: burst abandoned, nothing more returned.
        step(2);
        load_mem();
        issue(4'h8, 3'd0);
        step(LISTEN_DLY + DRAIN_DLY + 2);
        reset = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(rd_valid), 32'd0);
        check_eq("midrst_readptr", 32'(readPtr), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_data", 32'(rd_data), 32'd0);
        sb.delete();
        lq.delete();
        last_acc = -1000;
        step(2);
        @(negedge clk);
        reset = 1'b0;
        step(30);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        issue(4'h9, 3'd0);
        wait_drain();

        // Critical-word-first column (ignored when the feature is off).
        step(2);
        load_mem();
        issue(4'hA, 3'd6);
        wait_drain();

        // Random spacing with random tags and columns; drops fall out of the gap model.
        step(2);
        load_mem();
        for (int n = 0; n < 12; n++) begin
            issue(4'($urandom), 3'($urandom));
            step($urandom_range(2, 11));
        end
        wait_drain();
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_read_capture_ctrl.md
Name: ddr3_read_capture_ctrl

Overview:
- Sequencer for the 8-deep DDR3 read-capture ring buffer.
- Takes read-issue events from the command scheduler. Fires the one-cycle `listen` pulse at the programmed delay, then drains the 8 captured words through `readPtr`.
- Returns each word to the host read port, tagged and framed with valid/last.
- Polices command spacing so a burst is never overwritten before it is drained.

Parameters:
- DATA_W, 16, width of the ring-buffer data word.
- TAG_W, 4, width of the read tag carried from issue to return.
- LISTEN_DLY, 6, clk cycles from `rd_issue` to `listen` high (CL+AL minus preamble; minimum 1).
- DRAIN_DLY, 5, clk cycles from `listen` to the first `readPtr` drain cycle (strobe round-trip plus capture settle; minimum 5).
- MIN_GAP, 8, minimum clk cycles between accepted issues.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_issue  in  1  one-cycle pulse: a READ command was sent to DRAM this cycle.
- rd_tag_in  in  TAG_W  tag for the issued read, sampled with `rd_issue`.
- buf_dout  in  DATA_W  ring-buffer output; combinational from `readPtr`.
- err_clr  in  1  clears `overrun_err`.
- listen  out  1  one-cycle pulse to the ring buffer.
- readPtr  out  3  ring-buffer read pointer.
- rd_data  out  DATA_W  returned word.
- rd_valid  out  1  `rd_data` is valid this cycle.
- rd_tag  out  TAG_W  tag of the current word.
- rd_last  out  1  with `rd_valid`: 8th word of the burst.
- busy  out  1  a burst is in flight (pipeline non-empty or draining).
- overrun_err  out  1  sticky: an issue arrived inside MIN_GAP and was dropped.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous and active-high. While `reset` is asserted, all outputs are 0, pipelines are cleared, state is IDLE and the gap counter is saturated (ready).
- Issue acceptance:
  - A gap counter counts 0..MIN_GAP-1 and saturates.
  - `rd_issue` is accepted when the counter is saturated; acceptance resets the counter to 0.
  - `rd_issue` while the counter is not saturated: the issue is dropped, `overrun_err` is set, and the pipeline is unaffected.
- Launch pipeline:
  - An accepted issue in cycle T enters a shift pipeline of LISTEN_DLY+DRAIN_DLY stages, each holding valid plus tag.
  - `listen` is registered and is high in exactly cycle T+LISTEN_DLY.
  - The drain start tap fires in cycle T+LISTEN_DLY+DRAIN_DLY.
- State machine:
  - IDLE: `readPtr`=0. Tap fires -> DRAIN with k=0; the tap tag is latched.
  - DRAIN: `readPtr`=k, k increments every cycle. At k=7: tap fires -> DRAIN k=0 with the new tag (seamless back-to-back); otherwise -> IDLE.
  - A tap firing in DRAIN at k<7 is impossible under MIN_GAP>=8; the implementation asserts on it in simulation.
- Return path:
  - `rd_data` <= `buf_dout`, registered one cycle after each DRAIN cycle.
  - `rd_valid` is high for exactly 8 consecutive cycles per burst.
  - `rd_tag` is held for the whole burst; `rd_last` is high with the 8th word.
  - First-word latency is LISTEN_DLY+DRAIN_DLY+1 cycles after `rd_issue`.
- `busy` = any pipeline stage valid, OR state DRAIN, OR `rd_valid`.
- `overrun_err`: set on a dropped issue; cleared by `err_clr`. Set wins when set and clear occur in the same cycle.
- Reset mid-burst: the in-flight burst is abandoned and no further `rd_valid` is produced.

Optional Feature:
- Macro: DDR3_RDCTRL_CWF_EN (critical-word-first).
- When defined:
  - An extra input `rd_col` [2:0] is sampled with `rd_issue` and carried through the pipeline.
  - In DRAIN, `readPtr` = (rd_col + k) mod 8, wrapping 7->0.
  - `rd_last` still marks the 8th returned word.
- When undefined: no `rd_col` port; `readPtr` = k.

Test Plan:
- Single read: `rd_issue`, tag=0x5 at cycle 10 -> `listen` at cycle 16; `readPtr` 0..7 at cycles 21..28; `rd_valid` at cycles 22..29 with `rd_data`=r0..r7, `rd_tag`=0x5, `rd_last` at cycle 29; `busy` low from cycle 30.
- Back-to-back at MIN_GAP: issues at cycles 10 (tag 1) and 18 (tag 2) -> 16 contiguous `rd_valid` cycles 22..37 with no gap; `rd_tag` 1 then 2; `rd_last` at cycles 29 and 37.
- Overrun: issues at cycles 10 and 15 -> second issue dropped; `overrun_err`=1 from cycle 16; only one burst returned; `err_clr` at cycle 40 -> `overrun_err`=0 at cycle 41.
- Reset mid-drain: reset pulse at cycle 24 during the single-read case -> all outputs 0 immediately; no `rd_valid` afterwards; a new issue at cycle 40 completes normally.
- CWF (macro on): `rd_col`=6 -> `readPtr` sequence 6,7,0,1,2,3,4,5; `rd_last` on the word read from r5.
- Err set/clear collision: issue inside the gap in the same cycle as `err_clr` -> `overrun_err` remains 1.
